lifo_stack: RTL and testbench
=============================

# lifo_stack

Parametrised synchronous LIFO stack.
- Generalises the fixed 8-bit push/pop stack: configurable data width and depth, full/empty flags, an occupancy count, same-cycle push+pop (replace top), and overflow/underflow error pulses.
- Used as a scratch store for control sequencers and expression evaluators: push operands, pop results, with no external memory.

## Interface
Parameters:
- WIDTH, 8: data word width in bits (≥1).
- DEPTH, 16: number of entries (≥2, need not be a power of two).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high; dominates every other input.
- push  in  1  push write_data this cycle.
- pop  in  1  remove top-of-stack this cycle.
- write_data  in  WIDTH  data to push.
- read_data  out  WIDTH  registered top-of-stack (show-ahead); 0 when empty.
- count  out  $clog2(DEPTH+1)  current number of entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  one-cycle pulse: push rejected because full.
- underflow  out  1  one-cycle pulse: pop rejected because empty.

## Operation
- Reset values: count=0, empty=1, full=0, read_data=0, overflow=0, underflow=0.
- Storage contents are not cleared; they are unreachable until rewritten.
- read_data always shows the current top entry. The consumer samples read_data and asserts pop in the same cycle to consume it.
- Per-edge operation (priority top to bottom):
  - rst=1: apply reset values; push/pop ignored.
  - push=1, pop=1, not empty: REPLACE. Top becomes write_data; count unchanged; no error pulse, even when full.
  - push=1, pop=1, empty: treated as PUSH. count becomes 1; no underflow.
  - push=1, pop=0, not full: PUSH. Top becomes write_data, previous top moves down one level, count+1.
  - push=1, pop=0, full: ignored; overflow=1 for one cycle; contents and count unchanged.
  - pop=1, push=0, not empty: POP. Top becomes the entry below it (0 if count becomes 0), count−1.
  - pop=1, push=0, empty: ignored; underflow=1 for one cycle; read_data stays 0.
  - neither: hold.
- No wrap-around: the stack pointer saturates at 0 and DEPTH; rejected operations never corrupt stored data.
- Flags are derived from the registered count and update on the same edge as count.

## Timing
- Push latency 1: write_data presented at edge N is on read_data immediately after edge N.
- Pop latency 1: the new top is on read_data immediately after the popping edge. Back-to-back pops every cycle are supported.
- count, empty, full, overflow and underflow are all registered and change only on clock edges.
- Error pulses last exactly one cycle per rejected request. A request held for k cycles gives k consecutive pulses.
- No combinational path from any input to any output.

## Structure
- Package stack_pkg:
  - typedef stack_op_e {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE}, decoded once per cycle from push/pop/empty/full.
  - Helper constant function for the count width.
- Top register held separately from the array; the array holds entries below the top.
- Sub-module stack_mem:
  - Plain register array of DEPTH−1 words × WIDTH.
  - One synchronous write port, one asynchronous read port indexed by count.
  - No reset on the array.

## Test plan
All with WIDTH=8, DEPTH=4.
- Reset with push=1 held, then release: while rst=1, count=0, empty=1, read_data=0x00. First edge after release with write_data=0x01 → read_data=0x01, count=1.
- Push 0x01,0x02,0x03,0x04 on consecutive cycles → full=1, count=4, read_data=0x04. Fifth push of 0x05 → overflow pulse for one cycle, read_data stays 0x04, count=4.
- From full, pop each cycle → read_data 0x03,0x02,0x01,0x00; empty=1 after the fourth pop. Fifth pop → underflow pulse, count=0.
- Stack holds 0x0A,0x0B (top 0x0B); push=1 and pop=1 with write_data=0x0C → read_data=0x0C, count=2. Then pop → read_data=0x0A.
- Empty stack, push=1 and pop=1 with write_data=0x33 → count=1, read_data=0x33, no underflow. Full stack, push+pop with 0x44 → top=0x44, count=4, no overflow.
- Push 0x11,0x22, assert rst for one cycle while push=1 → count=0, read_data=0x00. Next push of 0x55 → read_data=0x55, count=1; a following pop → empty=1 (old data not resurfaced).

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and width helpers for the LIFO stack.
package stack_pkg;

  // Operation applied to the stack on a given clock edge.
  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stack_op_e;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Address bits for the below-top array of depth-1 words (at least 1).
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 2) ? $clog2(depth - 1) : 1;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Below-top storage: DEPTH-1 words, one sync write port, one async read port.
module stack_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH-1];

  // Write port; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read of the entry just below the top.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/lifo_stack.sv
// Parametrised synchronous LIFO with show-ahead top register, flags and error pulses.
module lifo_stack
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              write_data,
  output logic [WIDTH-1:0]              read_data,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          empty,
  output logic                          full,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned AW = addr_width(DEPTH);

  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] top_q;
  logic             overflow_q;
  logic             underflow_q;

  logic             is_empty;
  logic             is_full;
  stack_op_e        op;
  logic             overflow_d;
  logic             underflow_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    mem_raddr;
  logic [WIDTH-1:0] mem_rdata;

  // Decode the operation and the error pulses from the requests and registered flags.
  always_comb begin
    is_empty    = (count_q == '0);
    is_full     = (count_q == CW'(DEPTH));
    op          = OP_NONE;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (push && pop && !is_empty) begin
      op = OP_REPLACE;
    end else if (push && (pop || !is_full)) begin
      // push+pop on an empty stack falls through to here as a plain push
      op = OP_PUSH;
    end else if (push) begin
      overflow_d = 1'b1;
    end else if (pop && !is_empty) begin
      op = OP_POP;
    end else if (pop) begin
      underflow_d = 1'b1;
    end
  end

  // Array addressing: old top spills to slot count-1; the entry below top sits at count-2.
  always_comb begin
    mem_we    = (op == OP_PUSH) && !is_empty;
    mem_waddr = AW'(count_q - CW'(1));
    mem_raddr = (count_q >= CW'(2)) ? AW'(count_q - CW'(2)) : '0;
  end

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_stack_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (top_q),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Top-of-stack, occupancy and error-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      top_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      unique case (op)
        OP_PUSH: begin
          top_q   <= write_data;
          count_q <= count_q + CW'(1);
        end
        OP_POP: begin
          top_q   <= (count_q == CW'(1)) ? '0 : mem_rdata;
          count_q <= count_q - CW'(1);
        end
        OP_REPLACE: begin
          top_q <= write_data;
        end
        OP_NONE: ;
      endcase
    end
  end

  // Outputs come straight from registers or the registered count.
  always_comb begin
    read_data = top_q;
    count     = count_q;
    empty     = is_empty;
    full      = is_full;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack (WIDTH=8, DEPTH=4) against a queue-based model.
module tb_lifo_stack;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic         clk;
  logic         rst;
  logic         push;
  logic         pop;
  logic [W-1:0] write_data;
  logic [W-1:0] read_data;
  logic [2:0]   count;
  logic         empty;
  logic         full;
  logic         overflow;
  logic         underflow;

  int checks = 0;
  int errors = 0;

  // Model state: back of the queue is the top of the stack.
  logic [W-1:0] q[$];
  logic         exp_ovf;
  logic         exp_unf;

  lifo_stack #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .write_data (write_data),
    .read_data  (read_data),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic r, input logic p, input logic o, input logic [W-1:0] d);
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    if (r) begin
      q.delete();
    end else if (p && o && q.size() > 0) begin
      q[q.size()-1] = d;
    end else if (p && q.size() < D) begin
      q.push_back(d);
    end else if (p) begin
      exp_ovf = 1'b1;
    end else if (o && q.size() > 0) begin
      void'(q.pop_back());
    end else if (o) begin
      exp_unf = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] e_top;
    logic [2:0]   e_cnt;
    e_cnt = 3'(q.size());
    e_top = (q.size() > 0) ? q[q.size()-1] : '0;
    checks += 6;
    assert (read_data === e_top) else begin
      errors++;
      $error("FAIL %s read_data got %h exp %h", tag, read_data, e_top);
    end
    assert (count === e_cnt) else begin
      errors++;
      $error("FAIL %s count got %0d exp %0d", tag, count, e_cnt);
    end
    assert (empty === (e_cnt == 0)) else begin
      errors++;
      $error("FAIL %s empty got %b exp %b", tag, empty, (e_cnt == 0));
    end
    assert (full === (e_cnt == 3'(D))) else begin
      errors++;
      $error("FAIL %s full got %b exp %b", tag, full, (e_cnt == 3'(D)));
    end
    assert (overflow === exp_ovf) else begin
      errors++;
      $error("FAIL %s overflow got %b exp %b", tag, overflow, exp_ovf);
    end
    assert (underflow === exp_unf) else begin
      errors++;
      $error("FAIL %s underflow got %b exp %b", tag, underflow, exp_unf);
    end
  endtask

  // Drive one cycle, advance the model at the edge, check 1 time unit later.
  task automatic step(input logic r, input logic p, input logic o, input logic [W-1:0] d,
                      input string tag);
    rst        = r;
    push       = p;
    pop        = o;
    write_data = d;
    @(posedge clk);
    model_edge(r, p, o, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst        = 1'b1;
    push       = 1'b1;
    pop        = 1'b0;
    write_data = 8'hEE;
    exp_ovf    = 1'b0;
    exp_unf    = 1'b0;

    // Reset with push held, then release.
    step(1, 1, 0, 8'hEE, "rst_push0");
    step(1, 1, 0, 8'hEE, "rst_push1");
    step(0, 1, 0, 8'h01, "first_push");
    step(1, 0, 0, 8'h00, "rst_clean");

    // Fill, overflow twice, then drain and underflow twice.
    step(0, 1, 0, 8'h01, "fill1");
    step(0, 1, 0, 8'h02, "fill2");
    step(0, 1, 0, 8'h03, "fill3");
    step(0, 1, 0, 8'h04, "fill4");
    step(0, 1, 0, 8'h05, "ovf1");
    step(0, 1, 0, 8'h06, "ovf2");
    step(0, 0, 0, 8'h00, "ovf_clear");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00, "drain");
    step(0, 0, 1, 8'h00, "unf1");
    step(0, 0, 1, 8'h00, "unf2");
    step(0, 0, 0, 8'h00, "unf_clear");

    // Replace on a two-entry stack, then pop to the entry below.
    step(0, 1, 0, 8'h0A, "push_0a");
    step(0, 1, 0, 8'h0B, "push_0b");
    step(0, 1, 1, 8'h0C, "replace_0c");
    step(0, 0, 1, 8'h00, "pop_to_0a");
    step(0, 0, 1, 8'h00, "pop_empty");

    // push+pop on empty acts as push; push+pop on full replaces without overflow.
    step(0, 1, 1, 8'h33, "pp_empty");
    step(0, 1, 0, 8'h34, "fill_b");
    step(0, 1, 0, 8'h35, "fill_c");
    step(0, 1, 0, 8'h36, "fill_d");
    step(0, 1, 1, 8'h44, "pp_full");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00, "drain2");

    // Reset mid-use must not let stale data resurface.
    step(0, 1, 0, 8'h11, "push_11");
    step(0, 1, 0, 8'h22, "push_22");
    step(1, 1, 0, 8'h99, "rst_mid");
    step(0, 1, 0, 8'h55, "push_55");
    step(0, 0, 1, 8'h00, "pop_55");
    step(0, 0, 1, 8'h00, "unf_after_rst");

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom), 8'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
